// File: rtl/atualizador_atributos_if.sv
// Attribute-datapath bus: activity code in, attribute values and status flags out.
// The state controller is the master side; the attribute updater is the slave.
interface atualizador_atributos_if;
  logic [3:0] estado;
  logic [7:0] fome;
  logic [7:0] felicidade;
  logic [7:0] sono;
  logic [2:0] alerta;
  logic       morto;
  logic       tick;

  modport master (
    output estado,
    input  fome, felicidade, sono, alerta, morto, tick
  );

  modport slave (
    input  estado,
    output fome, felicidade, sono, alerta, morto, tick
  );
endinterface

// File: rtl/atualizador_atributos.sv
// Pet attribute updater: owns the fome/felicidade/sono registers and changes them once
// per prescaled game tick according to the current activity. Uses saturating 9-bit
// arithmetic, raises per-attribute low alerts and latches a sticky death flag.
module atualizador_atributos #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter logic [7:0]  INIT_VAL = 8'd200,
  parameter logic [7:0]  DEC      = 8'd1,
  parameter logic [7:0]  GAIN     = 8'd4,
  parameter logic [7:0]  LOW_THR  = 8'd32
) (
  input logic                     clk,
  input logic                     rst,
  atualizador_atributos_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE       = 4'b0000,
    DORMINDO   = 4'b0001,
    COMENDO    = 4'b0010,
    DANDO_AULA = 4'b0100,
    MORTO      = 4'b1000
  } estado_t;

  localparam int         CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0] DEC2  = 8'(2 * DEC);

  // Sum clamped to 255 instead of wrapping.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Difference clamped to 0 instead of wrapping; bit 8 is the borrow.
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[8] ? 8'h00 : d[7:0];
  endfunction

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             tick_q;

  logic [7:0] fome_q, felicidade_q, sono_q;
  logic [7:0] fome_n, felicidade_n, sono_n;
  logic [2:0] alerta_q, alerta_n;
  logic       morto_q, morto_n;

  // The wrap edge of the prescaler is the only edge on which attributes move.
  assign wrap = (cnt == CNT_W'(TICK_DIV - 1));

  // Prescaler counting 0..TICK_DIV-1; tick is high for the cycle after each wrap.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt    <= wrap ? '0 : cnt + 1'b1;
      tick_q <= wrap;
    end
  end

  // Candidate next attribute values for the activity presented on this edge.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    fome_n       = fome_q;
    felicidade_n = felicidade_q;
    sono_n       = sono_q;
    case (bus.estado)
      IDLE: begin
        fome_n       = sat_sub(fome_q, DEC);
        felicidade_n = sat_sub(felicidade_q, DEC);
        sono_n       = sat_sub(sono_q, DEC);
      end
      COMENDO: begin
        fome_n       = sat_add(fome_q, GAIN);
        felicidade_n = sat_sub(felicidade_q, DEC);
        sono_n       = sat_sub(sono_q, DEC);
      end
      DORMINDO: begin
        fome_n       = sat_sub(fome_q, DEC);
        sono_n       = sat_add(sono_q, GAIN);
      end
      DANDO_AULA: begin
        fome_n       = sat_sub(fome_q, DEC2);
        felicidade_n = sat_add(felicidade_q, GAIN);
        sono_n       = sat_sub(sono_q, DEC2);
      end
      default: ; // MORTO and every illegal code hold all attributes
    endcase
    morto_n  = (fome_n == 8'd0) || (felicidade_n == 8'd0) || (sono_n == 8'd0);
    alerta_n = {sono_n < LOW_THR, felicidade_n < LOW_THR, fome_n < LOW_THR};
  end

  // Attribute, alert and death registers; frozen once the pet has died.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fome_q       <= INIT_VAL;
      felicidade_q <= INIT_VAL;
      sono_q       <= INIT_VAL;
      alerta_q     <= {3{INIT_VAL < LOW_THR}};
      morto_q      <= 1'b0;
    end else if (wrap && !morto_q) begin
      fome_q       <= fome_n;
      felicidade_q <= felicidade_n;
      sono_q       <= sono_n;
      alerta_q     <= alerta_n;
      morto_q      <= morto_n;
    end
  end

  assign bus.fome       = fome_q;
  assign bus.felicidade = felicidade_q;
  assign bus.sono       = sono_q;
  assign bus.alerta     = alerta_q;
  assign bus.morto      = morto_q;
  assign bus.tick       = tick_q;

endmodule

// File: tb/tb_atualizador_atributos.sv
// Bench for atualizador_atributos: four instances with different reset values share one
// clock and reset. A per-instance behavioural model (plain integer arithmetic on the
// activity rules) is compared against every output on every falling edge; directed
// phases pin the model with hand-computed literal values, then random activity follows.
module tb_atualizador_atributos;

  localparam int         N        = 4;
  localparam int         TICK_DIV = 4;
  localparam int         DEC      = 1;
  localparam int         GAIN     = 4;
  localparam int         LOW_THR  = 8;
  localparam logic [7:0] INITS [N] = '{8'd10, 8'd253, 8'd2, 8'd9};

  localparam logic [3:0] E_IDLE  = 4'b0000;
  localparam logic [3:0] E_DORM  = 4'b0001;
  localparam logic [3:0] E_COME  = 4'b0010;
  localparam logic [3:0] E_AULA  = 4'b0100;
  localparam logic [3:0] E_MORTO = 4'b1000;

  typedef struct {
    int f;
    int h;
    int s;
  } attr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] estado     [N];
  logic [7:0] fome       [N];
  logic [7:0] felicidade [N];
  logic [7:0] sono       [N];
  logic [2:0] alerta     [N];
  logic       morto      [N];
  logic       tick       [N];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    atualizador_atributos_if bus ();
    assign bus.estado    = estado[g];
    assign fome[g]       = bus.fome;
    assign felicidade[g] = bus.felicidade;
    assign sono[g]       = bus.sono;
    assign alerta[g]     = bus.alerta;
    assign morto[g]      = bus.morto;
    assign tick[g]       = bus.tick;

    atualizador_atributos #(
      .TICK_DIV (TICK_DIV),
      .INIT_VAL (INITS[g]),
      .DEC      (8'(DEC)),
      .GAIN     (8'(GAIN)),
      .LOW_THR  (8'(LOW_THR))
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic attr_t rule(input attr_t a, input logic [3:0] e);
    attr_t n;
    n = a;
    case (e)
      E_IDLE: begin n.f = a.f - DEC;     n.h = a.h - DEC;  n.s = a.s - DEC;     end
      E_COME: begin n.f = a.f + GAIN;    n.h = a.h - DEC;  n.s = a.s - DEC;     end
      E_DORM: begin n.f = a.f - DEC;                       n.s = a.s + GAIN;    end
      E_AULA: begin n.f = a.f - 2 * DEC; n.h = a.h + GAIN; n.s = a.s - 2 * DEC; end
      default: ;
    endcase
    n.f = clamp(n.f);
    n.h = clamp(n.h);
    n.s = clamp(n.s);
    return n;
  endfunction

  function automatic bit any_zero(input attr_t a);
    return (a.f == 0) || (a.h == 0) || (a.s == 0);
  endfunction

  attr_t m_attr [N];
  bit    m_dead [N];
  int    m_cyc;   // rising edges since reset release

  // Model: every TICK_DIV-th edge after release applies the rule for the activity seen then.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc <= 0;
      for (int i = 0; i < N; i++) begin
        m_attr[i] <= '{int'(INITS[i]), int'(INITS[i]), int'(INITS[i])};
        m_dead[i] <= 1'b0;
      end
    end else begin
      m_cyc <= m_cyc + 1;
      if ((m_cyc + 1) % TICK_DIV == 0) begin
        for (int i = 0; i < N; i++) begin
          if (!m_dead[i]) begin
            m_attr[i] <= rule(m_attr[i], estado[i]);
            m_dead[i] <= any_zero(rule(m_attr[i], estado[i]));
          end
        end
      end
    end
  end

  // Compare every output of every instance against the model on each falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      check($sformatf("fome[%0d]", i),       fome[i],       m_attr[i].f);
      check($sformatf("felicidade[%0d]", i), felicidade[i], m_attr[i].h);
      check($sformatf("sono[%0d]", i),       sono[i],       m_attr[i].s);
      check($sformatf("alerta[%0d]", i),     alerta[i],
            {29'd0, m_attr[i].s < LOW_THR, m_attr[i].h < LOW_THR, m_attr[i].f < LOW_THR});
      check($sformatf("morto[%0d]", i),      morto[i],      m_dead[i]);
      check($sformatf("tick[%0d]", i),       tick[i],
            int'(m_cyc > 0 && m_cyc % TICK_DIV == 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [3:0] pick_estado();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1:    return E_IDLE;
      2, 3:    return E_COME;
      4, 5:    return E_DORM;
      6, 7:    return E_AULA;
      8:       return E_MORTO;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic check_attrs(input int i, input int f, input int h, input int s, input string tag);
    check($sformatf("%s fome[%0d]", tag, i),       fome[i],       f);
    check($sformatf("%s felicidade[%0d]", tag, i), felicidade[i], h);
    check($sformatf("%s sono[%0d]", tag, i),       sono[i],       s);
  endtask

  initial begin
    estado = '{E_IDLE, E_COME, E_AULA, E_IDLE};
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state straight after release.
    check_attrs(0, 10, 10, 10, "rst");
    check("rst alerta[2]", alerta[2], 3'b111);
    check("rst alerta[0]", alerta[0], 3'b000);
    check("rst tick[0]", tick[0], 0);

    // Phase 1: decay, clamp on gain, death, low alerts.
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("p1 tick c%0d", c), tick[0], int'(c % 4 == 0));
      if (c == 4) begin
        check_attrs(1, 255, 252, 252, "p1 come");
        check("p1 morto[1]", morto[1], 0);
        check_attrs(2, 0, 6, 0, "p1 aula");
        check("p1 morto[2]", morto[2], 1);
        check_attrs(3, 8, 8, 8, "p1 idle9");
        check("p1 alerta[3] t1", alerta[3], 3'b000);
        estado[2] = E_COME;
      end
      if (c == 8) begin
        check_attrs(3, 7, 7, 7, "p1 idle9 t2");
        check("p1 alerta[3] t2", alerta[3], 3'b111);
      end
    end
    check_attrs(0, 7, 7, 7, "p1 idle10");
    check_attrs(2, 0, 6, 0, "p1 dead hold");
    check("p1 morto[2] hold", morto[2], 1);

    // Phase 2: illegal code then MORTO hold on inst 0; estado toggling on inst 1.
    estado = '{4'b0011, E_IDLE, E_IDLE, E_IDLE};
    do_reset();
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      check($sformatf("p2 tick c%0d", c), tick[0], int'(c % 4 == 0));
      case (c)
        1:  estado[1] = E_DORM;
        2:  estado[1] = E_IDLE;
        4:  check_attrs(1, 252, 252, 252, "p2 toggle t1");
        5:  estado[1] = E_DORM;
        6:  estado[1] = E_IDLE;
        7:  estado[1] = E_DORM;
        8: begin
          check_attrs(1, 251, 252, 255, "p2 toggle t2");
          estado[1] = E_IDLE;
        end
        12: estado[0] = E_MORTO;
        default: ;
      endcase
    end
    check_attrs(0, 10, 10, 10, "p2 hold");
    check("p2 alerta[0]", alerta[0], 3'b000);
    check("p2 morto[0]", morto[0], 0);

    // Phase 3: asynchronous reset mid-tick, then prescaler restarts from zero.
    estado = '{E_IDLE, E_IDLE, E_IDLE, E_IDLE};
    do_reset();
    repeat (10) @(negedge clk);
    check_attrs(0, 8, 8, 8, "p3 pre");
    check("p3 morto[2] pre", morto[2], 1);
    #2 rst = 1'b1;
    #1;
    check_attrs(0, 10, 10, 10, "p3 async");
    check("p3 morto[2] async", morto[2], 0);
    check("p3 tick async", tick[0], 0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("p3 tick c%0d", c), tick[0], int'(c == 4));
    end

    // Phase 4: random activity with occasional mid-cycle resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) estado[i] = pick_estado();
      if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 8)) rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
